// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: one free-running 10-bit XNOR LFSR shared among NREQ
// requesters through a round-robin req/gnt/ack handshake. The winner receives
// the LFSR value captured at the grant edge. Seed loading and all-ones
// lock-up recovery are handled here.
module lfsr_rand_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter logic [9:0]  SEED = 10'h001
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] ack,
   input  logic            seed_load,
   input  logic [9:0]      seed,
   output logic [NREQ-1:0] gnt,
   output logic [9:0]      rnd,
   output logic            rnd_valid,
   output logic            busy,
   output logic            lockup_err
);

   localparam int unsigned LW = 10;
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [LW-1:0] LOCKUP  = 10'h3FF;
   localparam logic [LW-1:0] RECOVER = 10'h001;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [LW-1:0]   state, state_nx;
   logic            lock_nx;
   logic [0:0]      fsm, fsm_nx;
   logic [IW-1:0]   ptr, ptr_nx;
   logic [IW-1:0]   gidx, gidx_nx;
   logic [NREQ-1:0] gnt_nx;
   logic [LW-1:0]   rnd_nx;
   logic            rnd_valid_nx;
   logic            busy_nx;
   logic            found;
   logic [IW-1:0]   win;

   // LFSR next value: seed load wins over stepping; all-ones is never kept
   always_comb begin
      state_nx = {state[LW-2:0], ~(state[9] ^ state[6])};
      lock_nx  = lockup_err;
      if (seed_load) begin
         if (seed == LOCKUP) begin
            state_nx = RECOVER;
            lock_nx  = 1'b1;
         end else begin
            state_nx = seed;
         end
      end else if (state == LOCKUP) begin
         state_nx = RECOVER;
         lock_nx  = 1'b1;
      end
   end

   // Round-robin winner: first set req bit from ptr upward, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         logic [IW-1:0] cand;
         cand = IW'((32'(ptr) + off) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Handshake FSM next-state and registered-output values
   always_comb begin
      fsm_nx       = fsm;
      ptr_nx       = ptr;
      gidx_nx      = gidx;
      gnt_nx       = gnt;
      rnd_nx       = rnd;
      rnd_valid_nx = rnd_valid;
      busy_nx      = busy;
      case (fsm)
         IDLE: begin
            if (found) begin
               gnt_nx       = '0;
               gnt_nx[win]  = 1'b1;
               gidx_nx      = win;
               rnd_nx       = state;
               rnd_valid_nx = 1'b1;
               busy_nx      = 1'b1;
               fsm_nx       = GRANT;
            end
         end
         GRANT: begin
            // Release on ack from the grantee, or when it withdraws its request
            if (ack[gidx] || !req[gidx]) begin
               gnt_nx       = '0;
               rnd_valid_nx = 1'b0;
               busy_nx      = 1'b0;
               ptr_nx       = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
               fsm_nx       = IDLE;
            end
         end
         default: begin
            gnt_nx       = '0;
            rnd_valid_nx = 1'b0;
            busy_nx      = 1'b0;
            fsm_nx       = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SEED;
         lockup_err <= 1'b0;
         fsm        <= IDLE;
         ptr        <= '0;
         gidx       <= '0;
         gnt        <= '0;
         rnd        <= '0;
         rnd_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         lockup_err <= lock_nx;
         fsm        <= fsm_nx;
         ptr        <= ptr_nx;
         gidx       <= gidx_nx;
         gnt        <= gnt_nx;
         rnd        <= rnd_nx;
         rnd_valid  <= rnd_valid_nx;
         busy       <= busy_nx;
      end
   end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
Shares one 10-bit XNOR LFSR random source among NREQ game requesters (enemy spawners, hit-chance rollers, etc.) with a round-robin req/gnt/ack handshake. The LFSR free-runs every cycle. Its current value is captured and presented to the winning requester together with the grant. Seed loading and all-ones lock-up protection are also handled here, so no requester drives the LFSR directly.

Parameters:
NREQ, 4, number of requesters (2..8)
SEED, 10'h001, LFSR reset value; must not be 10'h3FF

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; held until acked or withdrawn
ack  input  NREQ  per-requester accept pulse; only the bit matching the current grant is honoured
seed_load  input  1  load seed into LFSR at next edge
seed  input  10  seed value
gnt  output  NREQ  one-hot grant, registered
rnd  output  10  random value for the granted requester, registered
rnd_valid  output  1  high while gnt is non-zero
busy  output  1  high in GRANT state
lockup_err  output  1  sticky flag: lock-up seed or state detected

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset values:
  - state = SEED
  - gnt = 0, rnd = 10'h000, rnd_valid = 0, busy = 0, lockup_err = 0
  - RR pointer ptr = 0, FSM = IDLE
  - Reset mid-grant drops gnt immediately, with no ack required.
- LFSR:
  - Every edge: state <= {state[8:0], ~(state[9]^state[6])}.
  - Maximal length, period 1023, excluded state 10'h3FF.
  - seed_load = 1 overrides the step: state <= seed.
  - If seed == 10'h3FF, load 10'h001 instead and set lockup_err.
  - If state is ever observed as 10'h3FF, force 10'h001 at the next edge and set lockup_err.
  - lockup_err clears only on reset.
- FSM states are IDLE and GRANT.
- IDLE:
  - If req != 0 at an edge, select winner i = first set req bit searching from ptr upward, wrapping modulo NREQ.
  - At that edge: gnt <= onehot(i), rnd <= the current state value (the pre-edge value), rnd_valid <= 1, go to GRANT.
  - If req == 0, outputs hold 0.
- GRANT:
  - gnt and rnd are held stable.
  - On an edge with ack[i] = 1: gnt <= 0, rnd_valid <= 0, ptr <= (i+1) mod NREQ, go to IDLE. rnd keeps its last value.
  - On an edge with req[i] = 0 and no ack[i] (withdrawal): same action as ack.
  - ack bits for non-granted indices are ignored.
  - Other req bits do not pre-empt the current grant.
- Minimum spacing:
  - IDLE lasts at least one cycle, so back-to-back grants are at least 2 cycles apart.
  - Grant-to-grant distance with immediate ack is exactly 2 edges.
- Latency: grant appears one edge after req is sampled in IDLE.
- Simultaneous events:
  - seed_load during GRANT does not change the held rnd.
  - seed_load in the same edge as a grant decision: rnd takes the pre-edge state, and the LFSR takes the seed.
- busy = (FSM == GRANT). gnt is always one-hot or zero.

Test Plan:
- Release reset, req=4'b0001 at first edge → gnt=4'b0001, rnd=10'h001, rnd_valid=1. The LFSR now holds 10'h003, and successive edges give 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE.
- req=4'b1111 held, each requester acks on its first grant cycle → grant order 0001, 0010, 0100, 1000, 0001, with one zero-gnt cycle between each grant.
- seed_load=1 with seed=10'h3FF → state=10'h001 next edge, lockup_err=1 and stays 1. seed_load with seed=10'h155 → state=10'h155, then 10'h2AA on the following edge.
- Free-run 1023 edges from reset with no seed_load → state returns to 10'h001, 10'h3FF is never observed, and the 1023 visited states are all distinct.
- Granted to requester 2 (gnt=4'b0100, ptr=0), req[2] drops without ack → gnt=0 next edge, ptr=3. ack[1] pulses during the grant with no effect.
- Assert reset asynchronously mid-GRANT → gnt, rnd_valid, busy drop to 0 without a clock edge. After release: state=10'h001, first grant goes to the lowest active req from index 0.
